// File: rtl/pc_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pc_fetch_pkg
//  Description : Shared types and constants for the fetch sequencer: state
//                encoding, fault codes, instruction size and the
//                alignment/range check used on every new program counter.
//  Revision    : 1.0  initial release
// ============================================================================
package pc_fetch_pkg;

  // Fetch sequencer states
  typedef enum logic [2:0] {
    RESET   = 3'd0,
    REQ     = 3'd1,
    WAIT    = 3'd2,
    DELIVER = 3'd3,
    HALT    = 3'd4
  } fetch_state_e;

  typedef logic [1:0] fault_t;

  localparam fault_t FAULT_NONE     = 2'd0;
  localparam fault_t FAULT_MISALIGN = 2'd1;
  localparam fault_t FAULT_RANGE    = 2'd2;
  localparam fault_t FAULT_TIMEOUT  = 2'd3;

  localparam int unsigned INST_BYTES = 4;

  // Misalignment takes precedence over range so a wrapped odd address
  // still reports the more specific cause.
  function automatic fault_t addr_check(input logic [31:0] addr,
                                        input logic [31:0] imem_bytes);
    fault_t res;
    res = FAULT_NONE;
    if (addr[1:0] != 2'b00) begin
      res = FAULT_MISALIGN;
    end else if (addr > (imem_bytes - 32'd4)) begin
      res = FAULT_RANGE;
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pc_fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : pc_fetch_ctrl_if
//  Description : Instruction-memory request/ready port between the fetch
//                sequencer (master) and instruction memory (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface pc_fetch_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/pc_fetch_ctrl_pc_next_sel.sv
`default_nettype none
// ============================================================================
//  Module      : pc_next_sel
//  Description : Chooses the next program counter (redirect target or the
//                sequential pc+4, 32-bit modulo) and classifies it as
//                aligned/in-range, misaligned or out of range.
//  Revision    : 1.0  initial release
// ============================================================================
module pc_next_sel
  import pc_fetch_pkg::*;
#(
  parameter int unsigned IMEM_BYTES = 1024
) (
  input  logic [31:0] pc,
  input  logic        use_target,
  input  logic [31:0] target,
  output logic [31:0] next_pc,
  output fault_t      next_fault
);

  // Next-address mux plus fault classification; wrap past 2^32 lands at a
  // small address only if pc was already out of range, so range check suffices.
  always_comb begin
    next_pc    = use_target ? target : (pc + 32'(INST_BYTES));
    next_fault = addr_check(next_pc, 32'(IMEM_BYTES));
  end

endmodule
`default_nettype wire

// File: rtl/pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pc_fetch_ctrl
//  Description : Fetch sequencer. Owns the program counter, issues one
//                instruction fetch at a time over a req/ready handshake,
//                delivers inst + pc to decode, honours stall and redirect,
//                and halts with a sticky fault code on bad addresses.
//                Optional feature macro: FETCH_TIMEOUT_EN (imem_ready
//                watchdog raising fault 3 after TIMEOUT_CYC cycles).
//  Revision    : 1.0  initial release
// ============================================================================
module pc_fetch_ctrl
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES  = 1024,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  pc_fetch_ctrl_if.master imem_bus,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [31:0]     redirect_target,
  output logic            inst_valid,
  output logic [31:0]     inst,
  output logic [31:0]     inst_pc,
  output logic [31:0]     pc,
  output fault_t          fault
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         req_q, req_d;
  logic [31:0]  inst_q, inst_d;
  logic [31:0]  inst_pc_q, inst_pc_d;
  logic         inst_valid_q, inst_valid_d;
  fault_t       fault_q, fault_d;
  logic         kill_q, kill_d;
  logic [31:0]  kill_target_q, kill_target_d;

  logic         use_target;
  logic [31:0]  target_sel;
  logic [31:0]  next_pc;
  fault_t       next_fault;
  fault_t       reset_fault;
  logic         do_launch;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
`else
  // The watchdog length only matters when the watchdog is built in.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |TIMEOUT_CYC;
`endif

  // A live redirect beats a recorded (killed) target; last redirect wins.
  assign use_target = redirect_valid | kill_q;
  assign target_sel = redirect_valid ? redirect_target : kill_target_q;

  pc_next_sel #(
    .IMEM_BYTES (IMEM_BYTES)
  ) u_pc_next_sel (
    .pc         (pc_q),
    .use_target (use_target),
    .target     (target_sel),
    .next_pc    (next_pc),
    .next_fault (next_fault)
  );

  // Next-state and next-output computation for the fetch sequencer.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    req_d         = req_q;
    inst_d        = inst_q;
    inst_pc_d     = inst_pc_q;
    inst_valid_d  = inst_valid_q;
    fault_d       = fault_q;
    kill_d        = kill_q;
    kill_target_d = kill_target_q;
    do_launch     = 1'b0;
    reset_fault   = addr_check(RESET_PC, 32'(IMEM_BYTES));
`ifdef FETCH_TIMEOUT_EN
    tmo_cnt_d     = '0;
`endif

    unique case (state_q)
      RESET: begin
        pc_d = RESET_PC;
        if (reset_fault != FAULT_NONE) begin
          state_d = HALT;
          fault_d = reset_fault;
          req_d   = 1'b0;
        end else begin
          state_d = REQ;
          req_d   = 1'b1;
        end
      end

      REQ, WAIT: begin
        if (imem_bus.imem_ready) begin
          if (use_target) begin
            // Response belongs to an abandoned path: drop it.
            do_launch = 1'b1;
          end else begin
            state_d      = DELIVER;
            req_d        = 1'b0;
            inst_valid_d = 1'b1;
            inst_d       = imem_bus.imem_rdata;
            inst_pc_d    = pc_q;
          end
        end else begin
          // Request cannot be withdrawn; remember where to go afterwards.
          state_d = WAIT;
          if (redirect_valid) begin
            kill_d        = 1'b1;
            kill_target_d = redirect_target;
          end
`ifdef FETCH_TIMEOUT_EN
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
          if (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1)) begin
            state_d = HALT;
            req_d   = 1'b0;
            kill_d  = 1'b0;
            fault_d = FAULT_TIMEOUT;
          end
`endif
        end
      end

      DELIVER: begin
        // Redirect drops the held instruction even under stall.
        if (redirect_valid || !stall) begin
          do_launch = 1'b1;
        end
      end

      HALT: begin
        req_d        = 1'b0;
        inst_valid_d = 1'b0;
      end

      default: begin
        state_d = HALT;
        req_d   = 1'b0;
      end
    endcase

    // Move to the next pc, refusing to issue a request to a bad address.
    if (do_launch) begin
      pc_d         = next_pc;
      kill_d       = 1'b0;
      inst_valid_d = 1'b0;
      if (next_fault != FAULT_NONE) begin
        state_d = HALT;
        req_d   = 1'b0;
        fault_d = next_fault;
      end else begin
        state_d = REQ;
        req_d   = 1'b1;
      end
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RESET;
      pc_q          <= RESET_PC;
      req_q         <= 1'b0;
      inst_q        <= 32'h0;
      inst_pc_q     <= RESET_PC;
      inst_valid_q  <= 1'b0;
      fault_q       <= FAULT_NONE;
      kill_q        <= 1'b0;
      kill_target_q <= 32'h0;
`ifdef FETCH_TIMEOUT_EN
      tmo_cnt_q     <= '0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      req_q         <= req_d;
      inst_q        <= inst_d;
      inst_pc_q     <= inst_pc_d;
      inst_valid_q  <= inst_valid_d;
      fault_q       <= fault_d;
      kill_q        <= kill_d;
      kill_target_q <= kill_target_d;
`ifdef FETCH_TIMEOUT_EN
      tmo_cnt_q     <= tmo_cnt_d;
`endif
    end
  end

  assign imem_bus.imem_req  = req_q;
  assign imem_bus.imem_addr = pc_q;
  assign pc                 = pc_q;
  assign inst               = inst_q;
  assign inst_pc            = inst_pc_q;
  assign inst_valid         = inst_valid_q;
  assign fault              = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_fetch_ctrl
//  Description : Self-checking bench for pc_fetch_ctrl. Acts as instruction
//                memory (word = fixed function of address) and keeps a
//                program-order model: expected next delivered pc, pending
//                discarded response, and handshake hold rules.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int unsigned IMEM_BYTES = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] pc;
  logic [1:0]  fault;

  pc_fetch_ctrl_if imem_if ();

  pc_fetch_ctrl #(
    .RESET_PC    (RESET_PC),
    .IMEM_BYTES  (IMEM_BYTES),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_bus        (imem_if),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .inst_valid      (inst_valid),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .pc              (pc),
    .fault           (fault)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] exp_pc;
  logic        discard;
  logic        p_req, p_ack, p_redir, p_valid, p_stall, p_disc;
  logic [31:0] p_addr, p_inst_pc;

  // Random-phase scratch
  logic        r_rdy, r_stl, r_rv;
  logic [31:0] r_tgt;
  int          wait_cnt;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $display("FAIL %s: observed %h expected %h", tag, got, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic model_reset();
    exp_pc  = RESET_PC;
    discard = 1'b0;
    p_req = 1'b0; p_ack = 1'b0; p_redir = 1'b0;
    p_valid = 1'b0; p_stall = 1'b0; p_disc = 1'b0;
    p_addr = 32'h0; p_inst_pc = 32'h0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
    imem_if.imem_ready = 1'b0; imem_if.imem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req",   32'(imem_if.imem_req), 32'd0);
    chk("rst_addr",  imem_if.imem_addr, RESET_PC);
    chk("rst_pc",    pc, RESET_PC);
    chk("rst_ipc",   inst_pc, RESET_PC);
    chk("rst_inst",  inst, 32'h0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    model_reset();
    rst_n = 1'b1;
  endtask

  // Drive one cycle of inputs, check current outputs against the model,
  // then advance to just after the next rising edge.
  task automatic step(input logic rdy, input logic stl, input logic rv, input logic [31:0] tgt);
    stall              = stl;
    redirect_valid     = rv;
    redirect_target    = tgt;
    imem_if.imem_ready = rdy;
    imem_if.imem_rdata = memf(imem_if.imem_addr);

    if (imem_if.imem_req && (!p_req || p_ack))
      chk("req_addr", imem_if.imem_addr, exp_pc);
    if (p_req && !p_ack) begin
      chk("req_hold",  32'(imem_if.imem_req), 32'd1);
      chk("addr_hold", imem_if.imem_addr, p_addr);
    end
    if (p_ack)
      chk("ack_latency", 32'(inst_valid), 32'(!(p_redir || p_disc)));
    if (p_redir)
      chk("redir_drop", 32'(inst_valid), 32'd0);
    if (p_valid && p_stall && !p_redir) begin
      chk("stall_hold_v",  32'(inst_valid), 32'd1);
      chk("stall_hold_pc", inst_pc, p_inst_pc);
    end
    if (inst_valid)
      chk("inst_data", inst, memf(inst_pc));
    chk("one_outstanding", 32'(inst_valid && imem_if.imem_req), 32'd0);
    if (inst_valid && !stl && !rv) begin
      chk("xfer_pc", inst_pc, exp_pc);
      exp_pc = exp_pc + 32'd4;
    end

    p_disc = discard;
    if (imem_if.imem_req && rdy) discard = 1'b0;
    else if (rv && imem_if.imem_req) discard = 1'b1;
    if (rv) exp_pc = tgt;

    p_req     = imem_if.imem_req;
    p_ack     = imem_if.imem_req && rdy;
    p_addr    = imem_if.imem_addr;
    p_redir   = rv;
    p_valid   = inst_valid;
    p_stall   = stl;
    p_inst_pc = inst_pc;

    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    do_reset();

    // Streaming with ready tied high: one instruction every 2 cycles
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("first_req",  32'(imem_if.imem_req), 32'd1);
    chk("first_addr", imem_if.imem_addr, RESET_PC);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("first_valid", 32'(inst_valid), 32'd1);
    chk("first_ipc",   inst_pc, RESET_PC);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("gap_valid", 32'(inst_valid), 32'd0);
    chk("addr_4",    imem_if.imem_addr, 32'h4);
    step(1'b1, 1'b0, 1'b0, 32'h0);

    // Stall five cycles with inst_pc=4 held
    for (int i = 0; i < 5; i++) begin
      chk("stall_v",   32'(inst_valid), 32'd1);
      chk("stall_ipc", inst_pc, 32'h4);
      chk("stall_req", 32'(imem_if.imem_req), 32'd0);
      step(1'b0, 1'b1, 1'b0, 32'h0);
    end
    chk("stall_end_ipc", inst_pc, 32'h4);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("req8_after_stall", 32'(imem_if.imem_req), 32'd1);

    // Ready delayed three cycles on address 8
    for (int i = 0; i < 4; i++) begin
      chk("slow_req",  32'(imem_if.imem_req), 32'd1);
      chk("slow_addr", imem_if.imem_addr, 32'h8);
      step((i == 3), 1'b0, 1'b0, 32'h0);
    end
    chk("slow_valid", 32'(inst_valid), 32'd1);
    chk("slow_ipc",   inst_pc, 32'h8);

    // Redirect to 0x40 while waiting on 0x10
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("addr_10", imem_if.imem_addr, 32'h10);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'h40);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("kill_no_valid", 32'(inst_valid), 32'd0);
    chk("kill_addr",     imem_if.imem_addr, 32'h40);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("kill_ipc", inst_pc, 32'h40);
    step(1'b0, 1'b0, 1'b1, 32'h80);
    chk("deliver_redir_addr", imem_if.imem_addr, 32'h80);

    // Randomised traffic against the model
    wait_cnt = 0;
    for (int i = 0; i < 600; i++) begin
      r_rdy = ($urandom_range(0, 99) < 55) || (wait_cnt >= 4);
      r_stl = ($urandom_range(0, 99) < 30);
      r_rv  = (imem_if.imem_req || inst_valid) &&
              (($urandom_range(0, 99) < 8) || (exp_pc >= 32'h300));
      r_tgt = $urandom_range(0, 127) * 4;
      if (imem_if.imem_req && !r_rdy) wait_cnt++;
      else wait_cnt = 0;
      step(r_rdy, r_stl, r_rv, r_tgt);
    end
    chk("rand_fault", 32'(fault), 32'd0);

    // Sequential run off the end of memory
    do_reset();
    for (int i = 0; i < 700 && fault == 2'd0; i++)
      step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("range_fault", 32'(fault), 32'd2);
    chk("range_pc",    pc, 32'h400);
    chk("range_req",   32'(imem_if.imem_req), 32'd0);
    repeat (3) step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("range_req_stays", 32'(imem_if.imem_req), 32'd0);
    chk("range_sticky",    32'(fault), 32'd2);

    // Misaligned redirect
    do_reset();
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'h22);
    chk("mis_fault", 32'(fault), 32'd1);
    chk("mis_pc",    pc, 32'h22);
    chk("mis_req",   32'(imem_if.imem_req), 32'd0);
    chk("mis_valid", 32'(inst_valid), 32'd0);

    // Reset pulse in the middle of a wait
    do_reset();
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("midwait_req", 32'(imem_if.imem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_req",   32'(imem_if.imem_req), 32'd0);
    chk("async_valid", 32'(inst_valid), 32'd0);
    do_reset();
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("refetch_req",  32'(imem_if.imem_req), 32'd1);
    chk("refetch_addr", imem_if.imem_addr, RESET_PC);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("refetch_ipc", inst_pc, RESET_PC);

`ifdef FETCH_TIMEOUT_EN
    // Watchdog: ready never arrives
    do_reset();
    step(1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 16; i++) begin
      chk("tmo_req", 32'(imem_if.imem_req), 32'd1);
      step(1'b0, 1'b0, 1'b0, 32'h0);
    end
    chk("tmo_fault", 32'(fault), 32'd3);
    chk("tmo_req_drop", 32'(imem_if.imem_req), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
